// File: rtl/sseg_num_display.sv
// rtl/sseg_num_display.sv - registered signed-decimal/hex formatter for DIGITS 7-segment displays
// Optional feature macro: SSEG_LZ_BLANK_EN (leading-zero blanking with floating minus sign).
module sseg_num_display #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [WIDTH-1:0]      x,
    input  logic                  mode,
    input  logic                  enable,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   segs
);
    // BCD width covers every WIDTH-bit magnitude; always wide enough for the hex nibbles too
    localparam int ND = (WIDTH + 4) / 3;
    localparam int NP = (ND > DIGITS) ? ND : DIGITS;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_FMT  = 2'd2;

    localparam logic [6:0] G_DASH  = 7'h3F;
    localparam logic [6:0] G_BLANK = 7'h7F;

    logic [1:0]           state;
    logic [WIDTH-1:0]     bin;
    logic [WIDTH-1:0]     mag;
    logic [4*ND-1:0]      bcd;
    logic [4*ND-1:0]      adj;
    logic [4*ND-1:0]      bcd_step;
    logic [4:0]           cnt;
    logic                 neg;
    logic [7*DIGITS-1:0]  res;
    logic [7*DIGITS-1:0]  fmt_res;
    logic                 ovf_r;
    logic                 fmt_ovf;
    logic                 done_r;
    logic [3:0]           dig [NP];
    logic [6:0]           g;
    int                   n;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    endfunction

    // -x in WIDTH bits, so the most negative value maps onto its own unsigned magnitude
    assign mag = x[WIDTH-1] ? (~x + WIDTH'(1)) : x;

    always_comb begin
        adj = bcd;
        for (int j = 0; j < ND; j++) begin
            if (adj[4*j +: 4] >= 4'd5) adj[4*j +: 4] = adj[4*j +: 4] + 4'd3;
        end
        bcd_step = {adj[4*ND-2:0], bin[WIDTH-1]};
    end

    always_comb begin
        for (int j = 0; j < NP; j++) dig[j] = 4'd0;
        for (int j = 0; j < ND; j++) dig[j] = bcd[4*j +: 4];
        n = 0;
        for (int j = 0; j < ND; j++) begin
            if (dig[j] != 4'd0) n = j;
        end
        fmt_ovf = (n >= DIGITS) || (neg && (n + 1 >= DIGITS));
        fmt_res = '1;
        g       = G_BLANK;
        for (int i = 0; i < DIGITS; i++) begin
`ifdef SSEG_LZ_BLANK_EN
            if (i <= n)                 g = glyph(dig[i]);
            else if (neg && i == n + 1) g = G_DASH;
            else                        g = G_BLANK;
`else
            g = glyph(dig[i]);
            if (neg && i == DIGITS - 1) g = G_DASH;
`endif
            if (fmt_ovf) g = G_DASH;
            fmt_res[7*i +: 7] = g;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            bin    <= '0;
            bcd    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            res    <= '1;
            ovf_r  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load) begin
                        cnt <= '0;
                        if (mode) begin
                            bcd   <= (4*ND)'(x);
                            neg   <= 1'b0;
                            state <= S_FMT;
                        end else begin
                            bcd   <= '0;
                            bin   <= mag;
                            neg   <= x[WIDTH-1];
                            state <= S_CONV;
                        end
                    end
                end
                S_CONV: begin
                    bcd <= bcd_step;
                    bin <= {bin[WIDTH-2:0], 1'b0};
                    if (cnt == 5'(WIDTH - 1)) state <= S_FMT;
                    else                      cnt   <= cnt + 5'd1;
                end
                S_FMT: begin
                    res    <= fmt_res;
                    ovf_r  <= fmt_ovf;
                    done_r <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy     = (state != S_IDLE);
    assign done     = done_r;
    assign overflow = ovf_r;
    assign segs     = enable ? res : '1;

endmodule

// File: tb/tb_sseg_num_display.sv
// tb/tb_sseg_num_display.sv - directed self-checking bench for sseg_num_display (4- and 2-digit builds)
module tb_sseg_num_display;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_a = 1'b0, mode_a = 1'b0, en_a = 1'b1;
    logic [7:0]  x_a = 8'h00;
    logic        busy_a, done_a, ovf_a;
    logic [27:0] segs_a;
    logic        load_b = 1'b0, mode_b = 1'b0, en_b = 1'b1;
    logic [7:0]  x_b = 8'h00;
    logic        busy_b, done_b, ovf_b;
    logic [13:0] segs_b;

    int checks = 0;
    int errors = 0;

`ifdef SSEG_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    always #5 clk = ~clk;

    sseg_num_display #(.WIDTH(8), .DIGITS(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .load(load_a), .x(x_a), .mode(mode_a), .enable(en_a),
        .busy(busy_a), .done(done_a), .overflow(ovf_a), .segs(segs_a)
    );

    sseg_num_display #(.WIDTH(8), .DIGITS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .load(load_b), .x(x_b), .mode(mode_b), .enable(en_b),
        .busy(busy_b), .done(done_b), .overflow(ovf_b), .segs(segs_b)
    );

    task automatic convert_a(input logic [7:0] v, input logic m, output int cyc);
        @(negedge clk);
        x_a = v; mode_a = m; load_a = 1'b1;
        @(posedge clk); #1 load_a = 1'b0;
        cyc = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (done_a) begin cyc = c; break; end
        end
    endtask

    task automatic convert_b(input logic [7:0] v, output int cyc);
        @(negedge clk);
        x_b = v; mode_b = 1'b0; load_b = 1'b1;
        @(posedge clk); #1 load_b = 1'b0;
        cyc = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (done_b) begin cyc = c; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        checks++; if (segs_a !== '1) begin errors++; $display("FAIL reset_segs: got %h expected %h", segs_a, 28'hFFFFFFF); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_a); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf_a); end
        checks++; if (segs_b !== '1) begin errors++; $display("FAIL reset_segs_b: got %h expected %h", segs_b, 14'h3FFF); end
        en_a = 1'b0; #1;
        checks++; if (segs_a !== '1) begin errors++; $display("FAIL reset_en0: got %h expected %h", segs_a, 28'hFFFFFFF); end
        en_a = 1'b1; #1;
        checks++; if (segs_a !== '1) begin errors++; $display("FAIL reset_en1: got %h expected %h", segs_a, 28'hFFFFFFF); end
    endtask

    task automatic test_decimal();
        int  cyc;
        bit  busy_dropped;
        logic [27:0] exp;
        exp = LZ ? {7'h7F, 7'h79, 7'h24, 7'h78} : {7'h40, 7'h79, 7'h24, 7'h78};
        @(negedge clk);
        x_a = 8'h7F; mode_a = 1'b0; load_a = 1'b1;
        @(posedge clk); #1 load_a = 1'b0;
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL dec_busy_start: got %b expected 1", busy_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL dec_done_early: got %b expected 0", done_a); end
        cyc = -1; busy_dropped = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (done_a) begin cyc = c; break; end
            if (!busy_a) busy_dropped = 1'b1;
        end
        checks++; if (busy_dropped) begin errors++; $display("FAIL dec_busy_hold: got busy low mid-conversion expected high"); end
        checks++; if (cyc != 9) begin errors++; $display("FAIL dec_latency: got %0d expected 9", cyc); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL dec_busy_done: got %b expected 0", busy_a); end
        checks++; if (segs_a !== exp) begin errors++; $display("FAIL dec_127: got %h expected %h", segs_a, exp); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL dec_127_ovf: got %b expected 0", ovf_a); end
        @(posedge clk); #1;
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL dec_done_pulse: got %b expected 0", done_a); end
    endtask

    task automatic test_values();
        logic [7:0]  vx   [3];
        logic [27:0] vexp [3];
        int cyc;
        vx[0] = 8'h80; vexp[0] = {7'h3F, 7'h79, 7'h24, 7'h00};
        vx[1] = 8'hFF; vexp[1] = LZ ? {7'h7F, 7'h7F, 7'h3F, 7'h79} : {7'h3F, 7'h40, 7'h40, 7'h79};
        vx[2] = 8'h00; vexp[2] = LZ ? {7'h7F, 7'h7F, 7'h7F, 7'h40} : {7'h40, 7'h40, 7'h40, 7'h40};
        for (int i = 0; i < 3; i++) begin
            convert_a(vx[i], 1'b0, cyc);
            checks++; if (cyc != 9) begin errors++; $display("FAIL val_latency x=%h: got %0d expected 9", vx[i], cyc); end
            checks++; if (segs_a !== vexp[i]) begin errors++; $display("FAIL val_segs x=%h: got %h expected %h", vx[i], segs_a, vexp[i]); end
            checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL val_ovf x=%h: got %b expected 0", vx[i], ovf_a); end
        end
    endtask

    task automatic test_hex();
        int cyc;
        logic [27:0] exp;
        exp = LZ ? {7'h7F, 7'h7F, 7'h08, 7'h12} : {7'h40, 7'h40, 7'h08, 7'h12};
        convert_a(8'hA5, 1'b1, cyc);
        checks++; if (cyc != 1) begin errors++; $display("FAIL hex_latency: got %0d expected 1", cyc); end
        checks++; if (segs_a !== exp) begin errors++; $display("FAIL hex_a5: got %h expected %h", segs_a, exp); end
    endtask

    task automatic test_load_ignored();
        int cyc;
        logic [27:0] exp;
        exp = LZ ? {7'h7F, 7'h7F, 7'h7F, 7'h12} : {7'h40, 7'h40, 7'h40, 7'h12};
        @(negedge clk);
        x_a = 8'h05; mode_a = 1'b0; load_a = 1'b1;
        @(posedge clk); #1;
        x_a = 8'h7F; mode_a = 1'b1;
        cyc = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (c == 3) load_a = 1'b0;
            if (done_a) begin cyc = c; break; end
        end
        load_a = 1'b0;
        checks++; if (cyc != 9) begin errors++; $display("FAIL ign_latency: got %0d expected 9", cyc); end
        checks++; if (segs_a !== exp) begin errors++; $display("FAIL ign_segs: got %h expected %h", segs_a, exp); end
    endtask

    task automatic test_back_to_back();
        int cyc, cyc2;
        convert_a(8'h7F, 1'b0, cyc);
        x_a = 8'h80; mode_a = 1'b0; load_a = 1'b1;
        cyc2 = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1 load_a = 1'b0;
            if (done_a) begin cyc2 = c; break; end
        end
        checks++; if (cyc2 != 10) begin errors++; $display("FAIL b2b_period: got %0d expected 10", cyc2); end
        checks++; if (segs_a !== {7'h3F, 7'h79, 7'h24, 7'h00}) begin errors++; $display("FAIL b2b_segs: got %h expected %h", segs_a, {7'h3F, 7'h79, 7'h24, 7'h00}); end
    endtask

    task automatic test_reset_mid_conv();
        int cyc;
        bit seen;
        convert_a(8'h7F, 1'b0, cyc);
        @(negedge clk);
        x_a = 8'h80; mode_a = 1'b0; load_a = 1'b1;
        @(posedge clk); #1 load_a = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (segs_a !== '1) begin errors++; $display("FAIL rst_mid_segs: got %h expected %h", segs_a, 28'hFFFFFFF); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy_a); end
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (done_a) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL rst_mid_done: got done pulse expected none"); end
        checks++; if (segs_a !== '1) begin errors++; $display("FAIL rst_mid_hold: got %h expected %h", segs_a, 28'hFFFFFFF); end
    endtask

    task automatic test_digits2();
        logic [7:0]  vx   [4];
        logic [13:0] vexp [4];
        logic        vovf [4];
        int cyc;
        vx[0] = 8'hFB; vexp[0] = {7'h3F, 7'h12}; vovf[0] = 1'b0;
        vx[1] = 8'hF6; vexp[1] = {7'h3F, 7'h3F}; vovf[1] = 1'b1;
        vx[2] = 8'd100; vexp[2] = {7'h3F, 7'h3F}; vovf[2] = 1'b1;
        vx[3] = 8'd99; vexp[3] = {7'h10, 7'h10}; vovf[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            convert_b(vx[i], cyc);
            checks++; if (cyc != 9) begin errors++; $display("FAIL d2_latency x=%h: got %0d expected 9", vx[i], cyc); end
            checks++; if (segs_b !== vexp[i]) begin errors++; $display("FAIL d2_segs x=%h: got %h expected %h", vx[i], segs_b, vexp[i]); end
            checks++; if (ovf_b !== vovf[i]) begin errors++; $display("FAIL d2_ovf x=%h: got %b expected %b", vx[i], ovf_b, vovf[i]); end
        end
    endtask

    task automatic test_enable();
        @(negedge clk) en_b = 1'b0; #1;
        checks++; if (segs_b !== 14'h3FFF) begin errors++; $display("FAIL en_blank: got %h expected %h", segs_b, 14'h3FFF); end
        repeat (2) @(posedge clk);
        @(negedge clk) en_b = 1'b1; #1;
        checks++; if (segs_b !== {7'h10, 7'h10}) begin errors++; $display("FAIL en_restore: got %h expected %h", segs_b, {7'h10, 7'h10}); end
    endtask

    initial begin
        test_reset();
        test_decimal();
        test_values();
        test_hex();
        test_load_ignored();
        test_back_to_back();
        test_reset_mid_conv();
        test_digits2();
        test_enable();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
